// File: rtl/host_bus_bridge_pkg.sv
// Shared definitions for the host bus bridge: FSM state encoding and synchronizer depth default.
package host_bus_bridge_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [2:0] {
        BRIDGE_IDLE         = 3'd0,
        BRIDGE_WR_SETUP     = 3'd1,
        BRIDGE_WR_STROBE    = 3'd2,
        BRIDGE_WR_HOLD      = 3'd3,
        BRIDGE_RD_ADDR      = 3'd4,
        BRIDGE_RD_DRIVE     = 3'd5,
        BRIDGE_WAIT_RELEASE = 3'd6
    } bridge_state_t;

endpackage

// File: rtl/host_bus_bridge_sync.sv
// N-stage flop synchronizer for a small vector of asynchronous strobes.
// Adds STAGES cycles of latency; reset value is a parameter so strobes can reset inactive.
module bus_sync
    import host_bus_bridge_pkg::*;
#(
    parameter int               WIDTH   = 3,
    parameter int               STAGES  = SYNC_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) stage_q[i] <= RST_VAL;
            else       stage_q[i] <= stage_d[i];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/host_bus_bridge.sv
// Bridges the asynchronous host strobe bus onto clk-synchronous register-file access signals.
// Writes produce one 1-cycle reg_wr pulse; reads drive host_data_out while the host holds rd.
module host_bus_bridge
    import host_bus_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_cs_n,
    input  logic                  host_rd_n,
    input  logic                  host_wr_n,
    input  logic [1:0]            host_be_n,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    output logic [DATA_WIDTH-1:0] host_data_out,
    output logic                  host_data_oe,
    output logic                  reg_en,
    output logic                  reg_rd,
    output logic                  reg_wr,
    output logic [1:0]            reg_be,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic                  protocol_err
);

    localparam int             FW       = $clog2(SYNC_STAGES + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(SYNC_STAGES);

    logic [2:0] strb_s;
    logic       cs, rd, wr;

    bus_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_strb_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({host_cs_n, host_rd_n, host_wr_n}),
        .q     (strb_s)
    );

    assign cs = ~strb_s[2];
    assign rd = cs & ~strb_s[1];
    assign wr = cs & ~strb_s[0];

    bridge_state_t         state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  err_q, err_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_data_in_q, reg_data_in_d;
    logic [1:0]            reg_be_q, reg_be_d;
    logic [DATA_WIDTH-1:0] host_data_out_q, host_data_out_d;
    logic                  reg_en_q, reg_en_d;
    logic                  reg_rd_q, reg_rd_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  host_data_oe_q, host_data_oe_d;

    always_comb begin
        state_d         = state_q;
        armed_d         = armed_q;
        err_d           = err_q;
        fill_d          = fill_q;
        reg_addr_d      = reg_addr_q;
        reg_data_in_d   = reg_data_in_q;
        reg_be_d        = reg_be_q;

        // Synchronizer outputs only reflect the pins once the reset value has flushed out,
        // so an idle observation is trusted only after that.
        if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);

        case (state_q)
            BRIDGE_IDLE: begin
                if (!rd && !wr && fill_q == FILL_MAX) armed_d = 1'b1;
                if (rd && wr) begin
                    err_d   = 1'b1;
                    state_d = BRIDGE_WAIT_RELEASE;
                end else if (armed_q && wr) begin
                    state_d       = BRIDGE_WR_SETUP;
                    reg_addr_d    = host_addr;
                    reg_data_in_d = host_data_in;
                    reg_be_d      = ~host_be_n;
                end else if (armed_q && rd) begin
                    state_d    = BRIDGE_RD_ADDR;
                    reg_addr_d = host_addr;
                end
            end
            BRIDGE_WR_SETUP:     state_d = BRIDGE_WR_STROBE;
            BRIDGE_WR_STROBE:    state_d = BRIDGE_WR_HOLD;
            BRIDGE_WR_HOLD:      state_d = BRIDGE_WAIT_RELEASE;
            BRIDGE_RD_ADDR:      state_d = rd ? BRIDGE_RD_DRIVE : BRIDGE_IDLE;
            BRIDGE_RD_DRIVE:     if (!rd) state_d = BRIDGE_IDLE;
            BRIDGE_WAIT_RELEASE: if (!rd && !wr) state_d = BRIDGE_IDLE;
            default:             state_d = BRIDGE_IDLE;
        endcase

        // Outputs are decoded from the next state so they register on the transition edge.
        reg_en_d = (state_d == BRIDGE_WR_SETUP) || (state_d == BRIDGE_WR_STROBE) ||
                   (state_d == BRIDGE_WR_HOLD)  || (state_d == BRIDGE_RD_ADDR)   ||
                   (state_d == BRIDGE_RD_DRIVE);
        reg_rd_d        = (state_d == BRIDGE_RD_ADDR) || (state_d == BRIDGE_RD_DRIVE);
        reg_wr_d        = (state_d == BRIDGE_WR_STROBE);
        host_data_oe_d  = (state_d == BRIDGE_RD_DRIVE);
        host_data_out_d = (state_d == BRIDGE_RD_DRIVE) ? reg_data_out : host_data_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= BRIDGE_IDLE;
            armed_q         <= 1'b0;
            err_q           <= 1'b0;
            fill_q          <= '0;
            reg_addr_q      <= '0;
            reg_data_in_q   <= '0;
            reg_be_q        <= '0;
            host_data_out_q <= '0;
            reg_en_q        <= 1'b0;
            reg_rd_q        <= 1'b0;
            reg_wr_q        <= 1'b0;
            host_data_oe_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            armed_q         <= armed_d;
            err_q           <= err_d;
            fill_q          <= fill_d;
            reg_addr_q      <= reg_addr_d;
            reg_data_in_q   <= reg_data_in_d;
            reg_be_q        <= reg_be_d;
            host_data_out_q <= host_data_out_d;
            reg_en_q        <= reg_en_d;
            reg_rd_q        <= reg_rd_d;
            reg_wr_q        <= reg_wr_d;
            host_data_oe_q  <= host_data_oe_d;
        end
    end

    assign host_data_out = host_data_out_q;
    assign host_data_oe  = host_data_oe_q;
    assign reg_en        = reg_en_q;
    assign reg_rd        = reg_rd_q;
    assign reg_wr        = reg_wr_q;
    assign reg_be        = reg_be_q;
    assign reg_addr      = reg_addr_q;
    assign reg_data_in   = reg_data_in_q;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Scoreboard bench for host_bus_bridge: stimulus pushes expected register-file writes and host reads.
module tb_host_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_cs_n = 1'b1, host_rd_n = 1'b1, host_wr_n = 1'b1;
    logic [1:0]  host_be_n = 2'b11;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_data_in = '0;
    logic [15:0] host_data_out;
    logic        host_data_oe;
    logic        reg_en, reg_rd, reg_wr;
    logic [1:0]  reg_be;
    logic [7:0]  reg_addr;
    logic [15:0] reg_data_in;
    logic [15:0] reg_data_out;
    logic        protocol_err;

    host_bus_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .host_cs_n(host_cs_n), .host_rd_n(host_rd_n), .host_wr_n(host_wr_n),
        .host_be_n(host_be_n), .host_addr(host_addr), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .host_data_oe(host_data_oe),
        .reg_en(reg_en), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_be(reg_be),
        .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return 16'h1232 + {8'h00, a};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // Register file that the bridge drives: commits on the falling edge of reg_wr.
    bit [15:0] mem [256];
    bit        written [256];
    assign reg_data_out = written[reg_addr] ? mem[reg_addr] : init_val(reg_addr);

    always @(negedge reg_wr) begin
        if (!reset) begin
            mem[reg_addr]     = merge(written[reg_addr] ? mem[reg_addr] : init_val(reg_addr),
                                      reg_data_in, reg_be);
            written[reg_addr] = 1'b1;
        end
    end

    // Reference model: expected register contents after each host write.
    logic [15:0] ref_mem [256];

    typedef struct { logic [7:0] addr; logic [15:0] data; logic [1:0] be; int cyc; } wr_exp_t;
    typedef struct { logic [15:0] data; int cyc; } rd_exp_t;
    wr_exp_t exp_wr [$];
    rd_exp_t exp_rd [$];

    // Monitor: write pulses and read-data launches are popped and compared here.
    int      wr_len = 0;
    int      wr_pulses = 0;
    bit      prev_oe = 1'b0;
    wr_exp_t we;
    rd_exp_t re;

    always @(negedge clk) begin
        if (reg_wr && wr_len == 0) begin
            wr_pulses++;
            check("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                we = exp_wr.pop_front();
                check("wr_addr", reg_addr, we.addr);
                check("wr_data", reg_data_in, we.data);
                check("wr_be", reg_be, we.be);
                check("wr_cycle", cyc, we.cyc + 4);
                check("wr_en", reg_en, 1);
            end
        end
        if (reg_wr) wr_len++;
        else if (wr_len != 0) begin
            check("wr_width", wr_len, 1);
            wr_len = 0;
        end
        if (host_data_oe && !prev_oe) begin
            check("rd_expected", 32'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0) begin
                re = exp_rd.pop_front();
                check("rd_data", host_data_out, re.data);
                check("rd_cycle", cyc, re.cyc + 4);
            end
        end
        if (host_data_oe) check("rd_en_rd", {reg_en, reg_rd}, 2'b11);
        prev_oe = host_data_oe;
    end

    task automatic host_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] ben,
                              input int hold);
        @(negedge clk);
        host_addr = a; host_data_in = d; host_be_n = ben;
        host_cs_n = 1'b0; host_wr_n = 1'b0;
        exp_wr.push_back('{a, d, ~ben, cyc});
        ref_mem[a] = merge(ref_mem[a], d, ~ben);
        repeat (hold) @(negedge clk);
        host_wr_n = 1'b1; host_cs_n = 1'b1;
        host_addr = 8'($urandom); host_data_in = 16'($urandom); host_be_n = 2'($urandom);
        repeat (6) @(negedge clk);
    endtask

    task automatic host_read(input logic [7:0] a, input int hold);
        logic [15:0] expv;
        @(negedge clk);
        host_addr = a; host_cs_n = 1'b0; host_rd_n = 1'b0;
        expv = ref_mem[a];
        exp_rd.push_back('{expv, cyc});
        repeat (hold) @(negedge clk);
        host_rd_n = 1'b1; host_cs_n = 1'b1; host_addr = 8'($urandom);
        @(negedge clk); check("oe_after_release1", host_data_oe, 1);
        @(negedge clk); check("oe_after_release2", host_data_oe, 1);
        @(negedge clk); check("oe_drop", host_data_oe, 0);
        check("rd_data_hold", host_data_out, expv);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // Reset with a write already in progress on the pins.
        host_addr = 8'h05; host_cs_n = 1'b0; host_wr_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_reg_en", reg_en, 0);
        check("rst_reg_rd", reg_rd, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_be", reg_be, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_data_in", reg_data_in, 0);
        check("rst_host_data_out", host_data_out, 0);
        check("rst_host_data_oe", host_data_oe, 0);
        check("rst_protocol_err", protocol_err, 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("stale_write_ignored", wr_pulses, 0);
        check("stale_write_no_en", reg_en, 0);
        host_wr_n = 1'b1; host_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        host_write(8'h05, 16'hA5A5, 2'b00, 4);
        check("stale_then_one_pulse", wr_pulses, 1);

        host_write(8'h06, 16'hBEEF, 2'b00, 5);
        check("beef_addr_held", reg_addr, 8'h06);
        check("beef_data_held", reg_data_in, 16'hBEEF);
        check("beef_be_held", reg_be, 2'b11);

        host_write(8'h09, 16'h7E81, 2'b10, 20);
        check("long_hold_pulses", wr_pulses, 3);

        host_read(8'h02, 6);

        // Simultaneous rd and wr: no access, sticky error.
        @(negedge clk);
        host_addr = 8'h03; host_cs_n = 1'b0; host_rd_n = 1'b0; host_wr_n = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("perr_no_access", {reg_en, reg_wr, reg_rd}, 3'b000);
        end
        check("perr_set", protocol_err, 1);
        host_rd_n = 1'b1; host_wr_n = 1'b1; host_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        host_write(8'h03, 16'h0F0F, 2'b01, 3);
        host_read(8'h03, 5);
        check("perr_sticky", protocol_err, 1);

        // Reset while the write strobe is high.
        @(negedge clk);
        host_addr = 8'h04; host_data_in = 16'h4444; host_be_n = 2'b00;
        host_cs_n = 1'b0; host_wr_n = 1'b0;
        exp_wr.push_back('{8'h04, 16'h4444, 2'b11, cyc});
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = reg_wr;
        end
        check("mid_reset_strobe_seen", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_wr_low", reg_wr, 0);
        check("mid_reset_en_low", reg_en, 0);
        check("mid_reset_perr_clear", protocol_err, 0);
        host_wr_n = 1'b1; host_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                host_write(a, 16'($urandom), 2'($urandom), $urandom_range(3, 12));
            else
                host_read(a, $urandom_range(4, 10));
        end

        repeat (5) @(negedge clk);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/host_bus_bridge.md
Name: host_bus_bridge

Overview:
- Sits directly upstream of the register file. Converts the asynchronous external host bus into clean, clk-synchronous register-file access signals.
- Host bus signals: active-low CS/RD/WR, address, data and byte enables.
- Register-file signals: en, rd, wr, be, addr and data_in.
- Generates a single well-formed write strobe per host write, so the register file's wr-clocked flops see exactly one falling edge with stable address, data and byte enables.
- Captures read data and drives it back to the host.

Parameters:
- ADDR_WIDTH, 8, width of host and register address bus.
- DATA_WIDTH, 16, width of data buses.
- SYNC_STAGES, 2, synchronizer flops on cs_n/rd_n/wr_n. Must be ≥2. Every latency below is quoted for 2 and grows by 1 cycle per extra stage.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_cs_n  in  1  host chip select, asynchronous
- host_rd_n  in  1  host read strobe, asynchronous
- host_wr_n  in  1  host write strobe, asynchronous
- host_be_n  in  2  host byte enables, active low
- host_addr  in  ADDR_WIDTH  host address
- host_data_in  in  DATA_WIDTH  host write data
- host_data_out  out  DATA_WIDTH  read data to host
- host_data_oe  out  1  host data pad output enable
- reg_en  out  1  register file access enable
- reg_rd  out  1  register file read
- reg_wr  out  1  register file write strobe, 1-cycle high pulse
- reg_be  out  2  byte enables, active high
- reg_addr  out  ADDR_WIDTH  captured address
- reg_data_in  out  DATA_WIDTH  captured write data
- reg_data_out  in  DATA_WIDTH  register file read data, combinational from reg_addr
- protocol_err  out  1  sticky: rd and wr both seen asserted

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high.
  - On reset: all outputs 0 except host_data_out = 0.
  - Synchronizer flops reset to 1 (inactive). State = IDLE; armed = 0; protocol_err = 0.
- Synchronization and sampling:
  - cs_n/rd_n/wr_n pass through SYNC_STAGES flops.
  - addr/data/be are sampled raw, only at capture. This is safe because the host holds them stable while its strobe is low.
  - Decoded signals: cs = ~cs_s, rd = cs & ~rd_s, wr = cs & ~wr_s.
- Armed flag:
  - armed is set only after a cycle with rd = wr = 0 is observed in IDLE.
  - A transaction already in progress at reset release is ignored until the host releases it.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_ADDR, RD_DRIVE, WAIT_RELEASE.
- IDLE transitions:
  - armed & wr & ~rd → WR_SETUP. Capture reg_addr = host_addr, reg_data_in = host_data_in, reg_be = ~host_be_n.
  - armed & rd & ~wr → RD_ADDR. Capture reg_addr.
  - rd & wr → set protocol_err, go to WAIT_RELEASE, no access performed.
- Write sequence:
  - WR_SETUP: reg_en = 1, reg_wr = 0.
  - WR_STROBE: reg_en = 1, reg_wr = 1.
  - WR_HOLD: reg_en = 1, reg_wr = 0.
  - Then WAIT_RELEASE.
  - reg_addr/reg_data_in/reg_be are stable from WR_SETUP through WR_HOLD.
- Write timing: pin falls before edge E0, giving synchronized wr at E1. Then WR_SETUP@E2, strobe high E3–E4, commit on the reg_wr falling edge at E4.
- Read sequence:
  - RD_ADDR: reg_en = 1, reg_rd = 1. Next state RD_DRIVE.
  - RD_DRIVE: reg_en = 1, reg_rd = 1, host_data_oe = 1. host_data_out is reloaded from reg_data_out every cycle.
  - Leave RD_DRIVE → IDLE in the cycle the synchronized rd deasserts. host_data_oe and reg_en drop on that same edge.
  - host_data_out holds its last value after exit.
- WAIT_RELEASE: all strobes 0. Go → IDLE when rd = 0 and wr = 0.
  - One host write therefore produces exactly one reg_wr pulse, however long host_wr_n stays low.
- Aborts:
  - cs/strobe deasserting during WR_SETUP/WR_STROBE: the write sequence still completes. Captured values are used.
  - cs/strobe deasserting during RD_ADDR: go → IDLE without driving.
- Reset mid-operation: IDLE on the next edge. reg_wr and host_data_oe go low at that same edge; no partial pulse is extended.
- protocol_err clears only on reset.

Decomposition:
- Shared package/header: state encoding constants (BRIDGE_IDLE … BRIDGE_WAIT_RELEASE, 3 bits) and the SYNC_STAGES default.
- One sub-module: bus_sync, an N-stage synchronizer with parameterized reset value. It is instantiated once per 3-bit strobe vector.

Test Plan:
- Reset release with host_wr_n already low, addr 0x05: no reg_wr pulse until wr_n goes high then low again. After that, exactly 1 pulse.
- Write 0xBEEF to addr 0x06, be_n = 2'b00: reg_wr high exactly 1 cycle, E3–E4. reg_addr = 0x06, reg_data_in = 0xBEEF, reg_be = 2'b11 from E2 through E5.
- Write with be_n = 2'b10, wr_n held low 20 cycles: exactly one pulse, reg_be = 2'b01, state remains WAIT_RELEASE until release.
- Read addr 0x02 with reg_data_out model returning 0x1234: host_data_oe rises at E3, host_data_out = 0x1234. oe drops 2 cycles after rd_n pin rises.
- rd_n and wr_n both low: no reg_en/reg_wr activity, protocol_err = 1 and stays 1 until reset.
- Reset asserted during WR_STROBE: reg_wr = 0 on the following edge, state IDLE, protocol_err = 0.
